// File: rtl/alu_flags_if.sv
// Issue/result bundle between the operand read ports and write-back for alu_flags_unit.
interface alu_flags_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;
    logic             flag_v;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, result_valid, result, result_hi,
        input  flag_z, flag_c, flag_n, flag_v
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, result_valid, result, result_hi,
        output flag_z, flag_c, flag_n, flag_v
    );
endinterface

// File: rtl/alu_flags_unit.sv
// Registered WIDTH-bit ALU with persistent Z/C/N/V flags, ADC/SBC carry chaining
// and a one-bit-per-cycle shift-add unsigned multiplier.
module alu_flags_unit #(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst_n,
    alu_flags_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state, state_nxt;
    logic               ready;
    logic               accept;
    logic               last_iter;
    logic [CW-1:0]      iter;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    logic               rv_q;
    logic [WIDTH-1:0]   res_q, res_hi_q;
    logic               z_q, c_q, n_q, v_q;

    logic [WIDTH:0]     ext;
    logic               cin;
    logic               alu_c, alu_v;

    assign accept    = bus.in_valid && ready;
    assign last_iter = (iter == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && bus.op == OP_MUL) state_nxt = MUL;
            MUL:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    // Carry-in comes straight from the flag register, so an op completing on the
    // same edge is already visible to the next ADC/SBC without a bypass path.
    always_comb begin
        cin   = bus.op[1] & c_q;
        ext   = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (bus.op)
            OP_ADD, OP_ADC: begin
                ext   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
                alu_c = ext[WIDTH];
                alu_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                ext   = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, cin};
                alu_c = ext[WIDTH];
                alu_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  ext = {1'b0, bus.a & bus.b};
            OP_OR:   ext = {1'b0, bus.a | bus.b};
            OP_XOR:  ext = {1'b0, bus.a ^ bus.b};
            default: ext = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q     <= 1'b0;
            res_q    <= '0;
            res_hi_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            iter     <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else begin
            rv_q <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (bus.op == OP_MUL) begin
                        mcand  <= {{WIDTH{1'b0}}, bus.a};
                        mplier <= bus.b;
                        acc    <= '0;
                        iter   <= '0;
                    end else begin
                        rv_q     <= 1'b1;
                        res_q    <= ext[WIDTH-1:0];
                        res_hi_q <= '0;
                        z_q      <= (ext[WIDTH-1:0] == '0);
                        c_q      <= alu_c;
                        n_q      <= ext[WIDTH-1];
                        v_q      <= alu_v;
                    end
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    iter   <= iter + CW'(1);
                end
                DONE: begin
                    rv_q     <= 1'b1;
                    res_q    <= acc[WIDTH-1:0];
                    res_hi_q <= acc[2*WIDTH-1:WIDTH];
                    z_q      <= (acc == '0);
                    c_q      <= |acc[2*WIDTH-1:WIDTH];
                    n_q      <= acc[2*WIDTH-1];
                    v_q      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = ready;
    assign bus.result_valid = rv_q;
    assign bus.result       = res_q;
    assign bus.result_hi    = res_hi_q;
    assign bus.flag_z       = z_q;
    assign bus.flag_c       = c_q;
    assign bus.flag_n       = n_q;
    assign bus.flag_v       = v_q;
endmodule
